marmot_core_rst_seq: RTL

Wishbone-controlled reset sequencer sitting directly upstream of MarmotCaravelChip. It replaces the raw "control register bit 0 drives the core reset" path with a registered, glitch-free core_rst_n. Release is delayed by a programmable hold count, and every re-assertion lasts a guaranteed minimum width. It also exposes control, status, hold and scratch registers on the Caravel Wishbone slave port.

---
 rtl/marmot_core_rst_seq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/marmot_core_rst_seq.sv
// Wishbone-controlled reset sequencer for MarmotCaravelChip: delayed, glitch-free
// core_rst_n release with a guaranteed minimum re-assertion width.
module marmot_core_rst_seq #(
  parameter logic [31:0] ADDR_BASE    = 32'h3000_0000,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEFAULT_HOLD = 16,
  parameter int unsigned MIN_ASSERT   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        core_rst_n,
  output logic [1:0]  core_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RUN    = 2'd2,
    ST_ASSERT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ASSERT_RELOAD = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] HOLD_RESET    = CNT_W'(DEFAULT_HOLD);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [31:0]        scratch_q, scratch_d;
  logic [31:0]        dat_q, dat_d;
  logic [7:0]         rel_q, rel_d;
  logic               run_q, run_d;
  logic               soft_q, soft_d;
  logic               ack_q;
  logic               rstn_q;

  logic               valid;
  logic               access;
  logic               wr;
  logic [31:0]        wmask;
  logic [31:0]        hold_rd;
  logic [31:0]        rd_data;
  logic               adr_unused;

  assign adr_unused = ^wbs_adr_i[1:0];

  assign valid  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  assign access = valid & ~ack_q;
  assign wr     = access & wbs_we_i;
  assign wmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  always_comb begin
    hold_rd = '0;
    hold_rd[CNT_W-1:0] = hold_q;
  end

  always_comb begin
    rd_data = '0;
    case (wbs_adr_i[3:2])
      2'd0: rd_data = {31'b0, run_q};
      2'd1: rd_data = {16'b0, rel_q, 5'b0, rstn_q, state_q};
      2'd2: rd_data = hold_rd;
      2'd3: rd_data = scratch_q;
      default: rd_data = '0;
    endcase
  end

  // Register file: read data is captured before the same-edge write lands.
  always_comb begin
    run_d     = run_q;
    soft_d    = 1'b0;
    hold_d    = hold_q;
    scratch_d = scratch_q;
    dat_d     = dat_q;
    if (access) begin
      dat_d = rd_data;
    end
    if (wr) begin
      case (wbs_adr_i[3:2])
        2'd0: begin
          if (wbs_sel_i[0]) begin
            run_d  = wbs_dat_i[0];
            soft_d = wbs_dat_i[1];
          end
        end
        2'd2: hold_d    = CNT_W'((hold_rd & ~wmask) | (wbs_dat_i & wmask));
        2'd3: scratch_d = (scratch_q & ~wmask) | (wbs_dat_i & wmask);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    case (state_q)
      ST_IDLE: begin
        if (run_q) begin
          state_d = ST_WAIT;
          cnt_d   = hold_q;
        end
      end
      ST_WAIT: begin
        if (!run_q) begin
          state_d = ST_IDLE;
        end else if (soft_q) begin
          cnt_d = hold_q;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
          if (rel_q != 8'hFF) begin
            rel_d = rel_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!run_q || soft_q) begin
          state_d = ST_ASSERT;
          cnt_d   = ASSERT_RELOAD;
        end
      end
      ST_ASSERT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // core_rst_n tracks the next state so it changes on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hold_q    <= HOLD_RESET;
      scratch_q <= '0;
      dat_q     <= '0;
      rel_q     <= '0;
      run_q     <= 1'b0;
      soft_q    <= 1'b0;
      ack_q     <= 1'b0;
      rstn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      scratch_q <= scratch_d;
      dat_q     <= dat_d;
      rel_q     <= rel_d;
      run_q     <= run_d;
      soft_q    <= soft_d;
      ack_q     <= access;
      rstn_q    <= (state_d == ST_RUN);
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign core_rst_n = rstn_q;
  assign core_state = state_q;

endmodule
